// File: rtl/vga_fb_fill_writer.sv
// Rectangle-fill engine for the 640x480 colour-index frame buffer: clips each
// command to the screen and streams one buffer write per cycle in raster order.
module vga_fb_fill_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int FB_BASE = 0
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              icmd_valid,
  output logic              ocmd_ready,
  input  logic [9:0]        icmd_x,
  input  logic [9:0]        icmd_y,
  input  logic [9:0]        icmd_w,
  input  logic [9:0]        icmd_h,
  input  logic [DATA_W-1:0] icmd_color,
  output logic              owren,
  output logic [ADDR_W-1:0] oaddr,
  output logic [DATA_W-1:0] odata,
  output logic              obusy,
  output logic              odone
);

  localparam logic [10:0]       H_RES_11   = 11'(H_RES);
  localparam logic [10:0]       V_RES_11   = 11'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A    = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] FB_BASE_A  = ADDR_W'(FB_BASE);
  localparam int                MUL_BITS   = $clog2(H_RES + 1);
  localparam logic [31:0]       H_RES_BITS = 32'(H_RES);

  typedef enum logic [1:0] {ST_IDLE, ST_CLIP, ST_FILL, ST_DONE} state_t;

  state_t state_reg, state_next;

  logic [9:0]        x_reg, y_reg, w_reg, h_reg;
  logic [DATA_W-1:0] color_reg;
  logic [10:0]       w_eff_reg, h_eff_reg, col_reg, row_reg;
  logic [ADDR_W-1:0] row_base_reg;

  logic              owren_reg, owren_next;
  logic              odone_reg, odone_next;
  logic [ADDR_W-1:0] oaddr_reg, oaddr_next;
  logic [DATA_W-1:0] odata_reg, odata_next;

  logic              empty_c, last_col_c, last_pix_c;
  logic [10:0]       rem_w_c, rem_h_c, w_eff_c, h_eff_c;
  logic [ADDR_W-1:0] row_base_c;

  // y*H_RES built as a sum of shifted copies of y, one per set bit of H_RES
  logic [ADDR_W-1:0] mul_acc [0:MUL_BITS];
  assign mul_acc[0] = '0;

  genvar gi;
  for (gi = 0; gi < MUL_BITS; gi++) begin : g_mul
    if (H_RES_BITS[gi]) begin : g_add
      assign mul_acc[gi+1] = mul_acc[gi] + (ADDR_W'(y_reg) << gi);
    end else begin : g_pass
      assign mul_acc[gi+1] = mul_acc[gi];
    end
  end

  assign empty_c    = ({1'b0, x_reg} >= H_RES_11) || ({1'b0, y_reg} >= V_RES_11) ||
                      (w_reg == '0) || (h_reg == '0);
  assign rem_w_c    = H_RES_11 - {1'b0, x_reg};
  assign rem_h_c    = V_RES_11 - {1'b0, y_reg};
  assign w_eff_c    = ({1'b0, w_reg} < rem_w_c) ? {1'b0, w_reg} : rem_w_c;
  assign h_eff_c    = ({1'b0, h_reg} < rem_h_c) ? {1'b0, h_reg} : rem_h_c;
  // row_base carries the left column so each write is simply row_base + col
  assign row_base_c = FB_BASE_A + mul_acc[MUL_BITS] + ADDR_W'(x_reg);
  assign last_col_c = (col_reg == w_eff_reg - 11'd1);
  assign last_pix_c = last_col_c && (row_reg == h_eff_reg - 11'd1);

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (icmd_valid) state_next = ST_CLIP;
      ST_CLIP: state_next = empty_c ? ST_DONE : ST_FILL;
      ST_FILL: if (last_pix_c) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    owren_next = (state_next == ST_FILL);
    odone_next = (state_next == ST_DONE);
    oaddr_next = oaddr_reg;
    odata_next = odata_reg;
    case (state_reg)
      ST_CLIP: begin
        if (!empty_c) begin
          oaddr_next = row_base_c;
          odata_next = color_reg;
        end
      end
      ST_FILL: begin
        if (!last_pix_c) begin
          oaddr_next = last_col_c ? (row_base_reg + H_RES_A) : (oaddr_reg + ADDR_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      w_eff_reg    <= '0;
      h_eff_reg    <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      row_base_reg <= '0;
      owren_reg    <= 1'b0;
      odone_reg    <= 1'b0;
      oaddr_reg    <= '0;
      odata_reg    <= '0;
    end else begin
      owren_reg <= owren_next;
      odone_reg <= odone_next;
      oaddr_reg <= oaddr_next;
      odata_reg <= odata_next;
      case (state_reg)
        ST_IDLE: begin
          if (icmd_valid) begin
            x_reg     <= icmd_x;
            y_reg     <= icmd_y;
            w_reg     <= icmd_w;
            h_reg     <= icmd_h;
            color_reg <= icmd_color;
          end
        end
        ST_CLIP: begin
          w_eff_reg    <= w_eff_c;
          h_eff_reg    <= h_eff_c;
          row_base_reg <= row_base_c;
          col_reg      <= '0;
          row_reg      <= '0;
        end
        ST_FILL: begin
          if (last_col_c) begin
            col_reg      <= '0;
            row_reg      <= row_reg + 11'd1;
            row_base_reg <= row_base_reg + H_RES_A;
          end else begin
            col_reg <= col_reg + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ocmd_ready = (state_reg == ST_IDLE);
  assign obusy      = (state_reg != ST_IDLE);
  assign owren      = owren_reg;
  assign odone      = odone_reg;
  assign oaddr      = oaddr_reg;
  assign odata      = odata_reg;

endmodule
